dp_rr_arbiter: RTL
==================

Name: dp_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready/pd datapath channel among NUM_REQ requesters.
- Holds a grant for a bounded burst of beats, then rotates priority.
- Registers the merged stream through a single full-throughput pipe stage.
- Sits in front of any shared dp channel (e.g. DMA read-return merge into one consumer); the dp agent drives each request port and the output port in the bench.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
PW, 32, payload width per beat
MAX_BURST, 8, maximum accepted beats per grant; SW = $clog2(NUM_REQ), BW = $clog2(MAX_BURST+1)

Ports:
clk  input  1  clock, all state on posedge
resetn  input  1  asynchronous active-low reset
cfg_burst  input  BW  beats per grant; sampled at grant
req_valid  input  NUM_REQ  per-requester valid
req_ready  output  NUM_REQ  per-requester ready, at most one bit high
req_pd  input  NUM_REQ*PW  payloads; requester i at bits [i*PW +: PW]
out_valid  output  1  merged stream valid (registered)
out_ready  input  1  downstream ready
out_pd  output  PW  merged payload (registered)
out_src  output  SW  index of requester that produced out_pd (registered)

Behaviour:
- Clock is clk; reset is asynchronous and active-low on resetn.
- Reset values: out_valid=0, out_pd=0, out_src=0, state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. req_ready=0 while state=IDLE.
- Reset mid-operation clears all state immediately; any in-flight beat is dropped.
- pipe_ok = !out_valid || out_ready.
- Output stage: when out_valid && !out_ready, out_pd/out_src are held stable.
- req_ready[i] = (state==GRANT) && (grant==i) && pipe_ok. It is combinational from registered state and out_ready.
- Accept = req_valid[grant] && req_ready[grant]. On accept, the next cycle has out_valid=1, out_pd=req_pd[grant], out_src=grant.
- If out_ready is high with no accept, out_valid goes to 0 the next cycle.
- FSM:
  - IDLE: if any req_valid, grant <= first requester with valid at or after rr_ptr (circular search), beat_cnt <= 0, latch burst limit, go to GRANT. Otherwise stay. Arbitration costs one cycle (no ready in IDLE).
  - GRANT, on accept: beat_cnt++. If beat_cnt+1 == limit, release.
  - GRANT, req_valid[grant]==0: release immediately (no beat accepted that cycle).
  - Release: rr_ptr <= (grant+1) mod NUM_REQ, go to IDLE.
  - GRANT while pipe blocked (!pipe_ok) and valid high: hold grant and count; no timeout.
- Burst limit: cfg_burst==0 is treated as 1; cfg_burst>MAX_BURST clamps to MAX_BURST. A cfg_burst change during GRANT has no effect until the next grant.
- Throughput: a granted requester with constant valid and out_ready=1 transfers 1 beat/cycle. Between grants there is exactly one idle (IDLE) cycle.
- Simultaneous requests: the winner is the lowest index at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
- Fairness: any requester holding valid is granted within NUM_REQ grants.
- Embedded assertions, disabled during reset:
  - $onehot0(req_ready).
  - out_valid && !out_ready |=> out_valid with $stable(out_pd) and $stable(out_src).
  - out_valid && out_ready |-> !$isunknown(out_pd).

Decomposition:
- Package dp_arb_pkg: state enum {IDLE, GRANT}; localparam helpers for SW/BW; function clamp_burst().
- Sub-module dp_rr_pick (combinational): inputs req_valid and rr_ptr; outputs winner index and any_valid. Implemented as a rotate, priority-encode, rotate-back.

Test Plan:
- Single requester 2, cfg_burst=4, 6 back-to-back beats 0xA0..0xA5, out_ready=1:
  - 4 beats at 1/cycle, out_src=2.
  - 1 IDLE bubble.
  - Remaining 2 beats.
  - Release, rr_ptr=3.
- All 4 requesters valid continuously, cfg_burst=2, after reset: grant order 0,1,2,3,0, each 2 beats, out_src sequence 0,0,1,1,2,2,3,3,0,0.
- Requester 1 granted, out_ready held low 5 cycles after first beat:
  - out_valid stays 1, out_pd/out_src stable.
  - req_ready[1]=0 throughout.
  - Beats resume with no loss or duplication when out_ready rises.
- Requester 0 drops valid after 1 of cfg_burst=8 beats while requester 3 is valid: release, then IDLE, then grant=3 (rr_ptr=1 skips idle 1,2).
- cfg_burst=0 then cfg_burst=15 with MAX_BURST=8: grants last 1 beat and 8 beats respectively.
- resetn asserted during GRANT with out_valid=1: out_valid, req_ready and out_src go to 0 asynchronously. After release, the first grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/dp_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin datapath arbiter.
package dp_arb_pkg;

   // Arbiter control state: IDLE picks a winner, GRANT streams its beats.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int sw_of(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Width able to hold every value 0..max_burst inclusive.
   function automatic int bw_of(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   // Beats allowed for one grant: zero means one, oversize clamps to the maximum.
   function automatic int clamp_burst(input int cfg, input int max_burst);
      if (cfg <= 0) begin
         return 1;
      end
      if (cfg > max_burst) begin
         return max_burst;
      end
      return cfg;
   endfunction

endpackage

// File: rtl/dp_rr_arbiter_pick.sv
// Circular priority picker: first requester with valid at or after rr_ptr.
// Built as rotate-right by rr_ptr, lowest-index priority encode, rotate back.
module dp_rr_pick
   import dp_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int SW      = sw_of(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [SW-1:0]      rr_ptr,
   output logic [SW-1:0]      winner,
   output logic               any_valid
);

   logic [NUM_REQ-1:0] rotated;
   int                 offset;

   // Bit j of rotated is requester (rr_ptr + j) mod NUM_REQ.
   assign rotated = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

   // Lowest set bit of the rotated vector is the closest requester after rr_ptr.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      offset = 0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rotated[j]) begin
            offset = j;
         end
      end
   end

   assign winner    = SW'((offset + int'(rr_ptr)) % NUM_REQ);
   assign any_valid = |req_valid;

endmodule

// File: rtl/dp_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready/pd channels into one
// registered output stream. A grant lasts up to a configurable burst of beats
// (or until the owner drops valid), then priority rotates past the owner.
module dp_rr_arbiter
   import dp_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int PW        = 32,
   parameter  int MAX_BURST = 8,
   localparam int SW        = sw_of(NUM_REQ),
   localparam int BW        = bw_of(MAX_BURST)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [BW-1:0]         cfg_burst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*PW-1:0] req_pd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PW-1:0]         out_pd,
   output logic [SW-1:0]         out_src
);

   arb_state_e    state_q;
   logic [SW-1:0] grant_q;
   logic [SW-1:0] rr_ptr_q;
   logic [BW-1:0] beat_cnt_q;
   logic [BW-1:0] beat_cnt_d;
   logic [BW-1:0] limit_q;
   logic          out_valid_q;
   logic [PW-1:0] out_pd_q;
   logic [SW-1:0] out_src_q;

   logic          pipe_ok;
   logic          granted_valid;
   logic [PW-1:0] granted_pd;
   logic          accept;
   logic [SW-1:0] next_ptr;
   logic [SW-1:0] winner;
   logic          any_valid;

   dp_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // The output register can take a new beat when empty or draining this cycle.
   assign pipe_ok       = !out_valid_q || out_ready;
   assign granted_valid = req_valid[grant_q];
   assign accept        = (state_q == GRANT) && granted_valid && pipe_ok;
   assign beat_cnt_d    = beat_cnt_q + BW'(1);
   assign next_ptr      = (grant_q == SW'(NUM_REQ - 1)) ? '0 : grant_q + SW'(1);

   // Payload lane of the current owner.
   always_comb begin
      granted_pd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == SW'(i)) begin
            granted_pd = req_pd[i*PW +: PW];
         end
      end
   end

   // Only the owner sees ready, and only when the output stage can absorb a beat.
   always_comb begin
      req_ready = '0;
      if ((state_q == GRANT) && pipe_ok) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   // Grant FSM: arbitrate in IDLE, count beats in GRANT, rotate priority on release.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state is updated with <= so every register samples pre-edge values regardless of statement order.
      if (!resetn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         limit_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  grant_q    <= winner;
                  beat_cnt_q <= '0;
                  limit_q    <= BW'(clamp_burst(int'(cfg_burst), MAX_BURST));
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (!granted_valid) begin
                  // Owner went quiet: give the channel up without taking a beat.
                  rr_ptr_q <= next_ptr;
                  state_q  <= IDLE;
               end else if (accept) begin
                  beat_cnt_q <= beat_cnt_d;
                  if (beat_cnt_d == limit_q) begin
                     rr_ptr_q <= next_ptr;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output pipe stage: load on accept, drain on ready, otherwise hold.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: the payload register is reset too, so out_pd is never X even before the first beat.
      if (!resetn) begin
         out_valid_q <= 1'b0;
         out_pd_q    <= '0;
         out_src_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_pd_q    <= granted_pd;
         out_src_q   <= grant_q;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pd    = out_pd_q;
   assign out_src   = out_src_q;

   // Protocol properties of the merged stream.
   a_ready_onehot0: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(req_ready));

   a_out_hold: assert property (@(posedge clk) disable iff (!resetn)
      out_valid && !out_ready |=> out_valid && $stable(out_pd) && $stable(out_src));

   a_out_known: assert property (@(posedge clk) disable iff (!resetn)
      out_valid && out_ready |-> !$isunknown(out_pd));

endmodule
